if_stage: RTL and testbench

- Instruction-fetch stage of the Lab3 MIPS core.
- Owns the program counter and drives the word address into the combinational instruction memory (32 words, async read).
- Registers the returned instruction and PC+4 into an IF/ID pipeline register for the decoder.
- Handles stall, redirect (branch/jump/jr resolved downstream), flush, halt, and a fetched-instruction counter.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/if_stage_if.sv | 34 +++
 rtl/if_stage_pc_reg.sv | 24 ++
 rtl/if_stage.sv | 122 ++++++++++++
 tb/tb_if_stage.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the Lab3 MIPS front end.
//   NOP_INSTR        : bubble instruction word (sll $0,$0,0)
//   RESET_PC_DEFAULT : default program counter after reset
//   PC_INC           : sequential fetch stride in bytes
//   fetch_state_e    : fetch FSM states
package cpu_pkg;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/if_stage_if.sv
// Bundle between the fetch stage and its surroundings: pipeline control in,
// instruction-memory port, IF/ID register and status out.
// Signal suffixes are from the fetch stage's point of view.
//   master : the fetch stage
//   slave  : control/memory/decode side (or a bench)
interface if_stage_if #(
  parameter int CNT_W = 16
);
  logic             stall_i;
  logic             redirect_i;
  logic [31:0]      redirect_pc_i;
  logic             flush_i;
  logic             halt_i;
  logic [31:0]      instr_addr_o;
  logic [31:0]      instr_i;
  logic [31:0]      ifid_instr_o;
  logic [31:0]      ifid_pc4_o;
  logic             ifid_valid_o;
  logic             misalign_o;
  logic             oor_o;
  logic [CNT_W-1:0] fetch_cnt_o;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, flush_i, halt_i, instr_i,
    output instr_addr_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o,
           misalign_o, oor_o, fetch_cnt_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, flush_i, halt_i, instr_i,
    input  instr_addr_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o,
           misalign_o, oor_o, fetch_cnt_o
  );
endinterface

// File: rtl/if_stage_pc_reg.sv
// Program counter register with load enable.
//   clk_i  : clock
//   rst_i  : async active-low reset, loads RESET_PC
//   ld_i   : load pc_d_i on the rising edge
//   pc_d_i : next PC
//   pc_q_o : current PC
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ld_i,
  input  logic [31:0] pc_d_i,
  output logic [31:0] pc_q_o
);
  logic [31:0] pc_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)    pc_q <= RESET_PC;
    else if (ld_i) pc_q <= pc_d_i;
  end

  assign pc_q_o = pc_q;
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage. Owns the PC, addresses the async instruction
// memory, and registers {instr, PC+4, valid} into IF/ID.
//   clk_i : clock, rising edge
//   rst_i : async active-low reset
//   bus   : if_stage_if.master -- stall/redirect/flush/halt in, memory
//           address out / instruction in, IF/ID + misalign/oor/fetch count out
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          IMEM_WORDS = 32,
  parameter int          CNT_W      = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  if_stage_if.master    bus
);
  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d, pc4;
  logic             pc_ld;
  logic [31:0]      ifid_instr_q, ifid_instr_d;
  logic [31:0]      ifid_pc4_q, ifid_pc4_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic             fetch_en;   // a real instruction enters IF/ID this edge

  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .ld_i  (pc_ld),
    .pc_d_i(pc_d),
    .pc_q_o(pc_q)
  );

  assign pc4 = pc_q + PC_INC;

  always_comb begin
    state_d      = state_q;
    pc_ld        = 1'b0;
    pc_d         = pc4;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    misalign_d   = misalign_q;
    fetch_en     = 1'b0;
    case (state_q)
      BOOT: begin
        fetch_en = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        if (bus.halt_i) begin
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
          state_d      = HALTED;
        end else if (bus.redirect_i) begin
          // Redirect wins over stall: the word in flight is wrong-path.
          pc_ld        = 1'b1;
          pc_d         = {bus.redirect_pc_i[31:2], 2'b00};
          misalign_d   = misalign_q | (|bus.redirect_pc_i[1:0]);
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else if (bus.stall_i) begin
          if (bus.flush_i) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
          end
        end else if (bus.flush_i) begin
          // PC still advances; only the fetched word is squashed.
          pc_ld        = 1'b1;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else begin
          fetch_en = 1'b1;
        end
      end
      HALTED: begin
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end
      default: state_d = BOOT;
    endcase
    if (fetch_en) begin
      pc_ld        = 1'b1;
      ifid_instr_d = bus.instr_i;
      ifid_pc4_d   = pc4;
      ifid_valid_d = 1'b1;
    end
  end

  // Saturating count of real fetches.
  assign fetch_cnt_d = (fetch_en && (fetch_cnt_q != '1)) ? fetch_cnt_q + CNT_W'(1)
                                                         : fetch_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= BOOT;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= 32'h0;
      ifid_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      misalign_q   <= misalign_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  assign bus.instr_addr_o = pc_q;
  assign bus.ifid_instr_o = ifid_instr_q;
  assign bus.ifid_pc4_o   = ifid_pc4_q;
  assign bus.ifid_valid_o = ifid_valid_q;
  assign bus.misalign_o   = misalign_q;
  assign bus.fetch_cnt_o  = fetch_cnt_q;
  // Word index compared unsigned; fetch is not blocked by this flag.
  assign bus.oor_o        = ({2'b00, pc_q[31:2]} >= 32'(IMEM_WORDS));
endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  logic clk = 1'b0;
  logic rst_i;
  logic sat_rst_n;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  logic [31:0] mem [32];

  if_stage_if #(.CNT_W(16)) bus ();
  if_stage_if #(.CNT_W(4))  sbus ();

  if_stage #(.RESET_PC(32'h0), .IMEM_WORDS(32), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .bus(bus));
  if_stage #(.RESET_PC(32'h0), .IMEM_WORDS(32), .CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(sat_rst_n), .bus(sbus));

  always #5 clk = ~clk;

  // Memory wraps on the low word-address bits.
  assign bus.instr_i  = mem[bus.instr_addr_o[6:2]];
  assign sbus.instr_i = mem[sbus.instr_addr_o[6:2]];

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc = 32'h0, m_instr = 32'h0, m_pc4 = 32'h0;
  logic        m_valid = 1'b0, m_mis = 1'b0, m_booted = 1'b0, m_halted = 1'b0;
  int unsigned m_cnt = 0;

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_mis = 1'b0; m_cnt = 0; m_booted = 1'b0; m_halted = 1'b0;
    end else begin
      logic take;
      take = 1'b0;
      if (m_halted) begin
        m_instr = 32'h0; m_valid = 1'b0;
      end else if (!m_booted) begin
        take = 1'b1; m_booted = 1'b1;
      end else if (bus.halt_i) begin
        m_instr = 32'h0; m_valid = 1'b0; m_halted = 1'b1;
      end else if (bus.redirect_i) begin
        if (bus.redirect_pc_i % 4 != 0) m_mis = 1'b1;
        m_pc = bus.redirect_pc_i - (bus.redirect_pc_i % 4);
        m_instr = 32'h0; m_valid = 1'b0;
      end else if (bus.stall_i) begin
        if (bus.flush_i) begin m_instr = 32'h0; m_valid = 1'b0; end
      end else if (bus.flush_i) begin
        m_instr = 32'h0; m_valid = 1'b0; m_pc = m_pc + 4;
      end else begin
        take = 1'b1;
      end
      if (take) begin
        m_instr = mem[(m_pc / 4) % 32];
        m_pc4   = m_pc + 4;
        m_valid = 1'b1;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        m_pc    = m_pc + 4;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("addr",     bus.instr_addr_o, m_pc);
    check("ifid_ins", bus.ifid_instr_o, m_instr);
    check("ifid_pc4", bus.ifid_pc4_o,   m_pc4);
    check("valid",    {31'b0, bus.ifid_valid_o}, {31'b0, m_valid});
    check("misalign", {31'b0, bus.misalign_o},   {31'b0, m_mis});
    check("oor",      {31'b0, bus.oor_o},        {31'b0, (m_pc / 4) >= 32});
    check("cnt",      {16'b0, bus.fetch_cnt_o},  m_cnt);
  end

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic idle();
    bus.stall_i = 0; bus.redirect_i = 0; bus.flush_i = 0; bus.halt_i = 0;
    bus.redirect_pc_i = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int unsigned cnt_before;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0] = 32'h2001_0005;
    mem[1] = 32'h2002_000A;
    rst_i = 1'b0; sat_rst_n = 1'b0;
    idle();
    sbus.stall_i = 0; sbus.redirect_i = 0; sbus.flush_i = 0; sbus.halt_i = 0;
    sbus.redirect_pc_i = 32'h0;

    // Reset / boot
    tick(3);
    check("rst_addr",  bus.instr_addr_o, 32'h0);
    check("rst_valid", {31'b0, bus.ifid_valid_o}, 32'h0);
    rst_i = 1'b1;
    tick();
    check("boot_ins",  bus.ifid_instr_o, 32'h2001_0005);
    check("boot_pc4",  bus.ifid_pc4_o,   32'h4);
    check("boot_addr", bus.instr_addr_o, 32'h4);
    tick();
    check("e2_ins", bus.ifid_instr_o, 32'h2002_000A);
    check("e2_cnt", {16'b0, bus.fetch_cnt_o}, 32'd2);

    // Stall at PC=8
    bus.stall_i = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("stall_addr", bus.instr_addr_o, 32'h8);
      check("stall_ins",  bus.ifid_instr_o, 32'h2002_000A);
      check("stall_cnt",  {16'b0, bus.fetch_cnt_o}, 32'd2);
    end
    bus.stall_i = 0;
    tick();
    check("unstall_ins", bus.ifid_instr_o, mem[2]);
    check("unstall_pc4", bus.ifid_pc4_o,   32'd12);

    // Redirect beats stall at PC=16
    tick();
    check("pc16", bus.instr_addr_o, 32'd16);
    bus.stall_i = 1; bus.redirect_i = 1; bus.redirect_pc_i = 32'h40;
    tick();
    idle();
    check("redir_addr",  bus.instr_addr_o, 32'h40);
    check("redir_valid", {31'b0, bus.ifid_valid_o}, 32'h0);
    check("redir_ins",   bus.ifid_instr_o, 32'h0);
    tick();
    check("redir_pc4", bus.ifid_pc4_o, 32'h44);

    // Misaligned redirect
    bus.redirect_i = 1; bus.redirect_pc_i = 32'h46;
    tick();
    idle();
    check("mis_addr", bus.instr_addr_o, 32'h44);
    check("mis_flag", {31'b0, bus.misalign_o}, 32'h1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("mis_sticky", {31'b0, bus.misalign_o}, 32'h1);
    end

    // Randomized traffic, checked every cycle by the model
    for (int k = 0; k < 400; k++) begin
      bus.stall_i    = ($urandom % 4) == 0;
      bus.flush_i    = ($urandom % 6) == 0;
      bus.redirect_i = ($urandom % 8) == 0;
      case ($urandom % 6)
        0:       bus.redirect_pc_i = $urandom;
        1:       bus.redirect_pc_i = ($urandom % 40) * 4 + ($urandom % 4);
        default: bus.redirect_pc_i = ($urandom % 40) * 4;
      endcase
      tick();
    end
    idle();

    // Flush at PC=20, then halt
    bus.redirect_i = 1; bus.redirect_pc_i = 32'd20;
    tick();
    idle();
    check("pc20", bus.instr_addr_o, 32'd20);
    cnt_before = m_cnt;
    bus.flush_i = 1;
    tick();
    idle();
    check("flush_valid", {31'b0, bus.ifid_valid_o}, 32'h0);
    check("flush_addr",  bus.instr_addr_o, 32'd24);
    check("flush_cnt",   {16'b0, bus.fetch_cnt_o}, cnt_before);
    bus.halt_i = 1;
    tick();
    idle();
    bus.redirect_i = 1; bus.redirect_pc_i = 32'h100;  // ignored once halted
    for (int k = 0; k < 5; k++) begin
      tick();
      check("halt_addr",  bus.instr_addr_o, 32'd24);
      check("halt_valid", {31'b0, bus.ifid_valid_o}, 32'h0);
    end
    idle();

    // Asynchronous reset in mid-cycle
    #2 rst_i = 1'b0;
    #1;
    check("arst_addr",  bus.instr_addr_o, 32'h0);
    check("arst_valid", {31'b0, bus.ifid_valid_o}, 32'h0);
    check("arst_ins",   bus.ifid_instr_o, 32'h0);
    check("arst_pc4",   bus.ifid_pc4_o, 32'h0);
    check("arst_mis",   {31'b0, bus.misalign_o}, 32'h0);
    check("arst_cnt",   {16'b0, bus.fetch_cnt_o}, 32'h0);
    tick();
    rst_i = 1'b1;

    // Boundary: out-of-range flag and PC wrap
    tick();
    bus.redirect_i = 1; bus.redirect_pc_i = 32'h78;
    tick();
    idle();
    tick();
    check("oor124_addr", bus.instr_addr_o, 32'd124);
    check("oor124",      {31'b0, bus.oor_o}, 32'h0);
    tick();
    check("oor128_addr", bus.instr_addr_o, 32'd128);
    check("oor128",      {31'b0, bus.oor_o}, 32'h1);
    bus.redirect_i = 1; bus.redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    idle();
    tick();
    check("wrap_addr", bus.instr_addr_o, 32'h0);
    check("wrap_pc4",  bus.ifid_pc4_o,   32'h0);

    // Counter saturation on the 4-bit instance
    sat_rst_n = 1'b1;
    tick(14);
    check("sat14", {28'b0, sbus.fetch_cnt_o}, 32'd14);
    tick();
    check("sat15", {28'b0, sbus.fetch_cnt_o}, 32'd15);
    tick(3);
    check("sat_hold", {28'b0, sbus.fetch_cnt_o}, 32'd15);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
